// File: rtl/reg_wb_arbiter.sv
// Two-requester register-file writeback arbiter: A has priority, B is forced
// through after STARVE_MAX consecutive denials. The write port is registered.
//
// state   | meaning
// --------+--------------------------------------------------------------
// PRI_A   | pipeline requester A wins; B wins only when A is idle
// FORCE_B | B has been starved; B wins this cycle, then back to PRI_A
module reg_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        a_valid_i,
  input  logic [4:0]  a_addr_i,
  input  logic [31:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [4:0]  b_addr_i,
  input  logic [31:0] b_data_i,
  output logic        b_ready_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic [3:0]  starve_cnt_o
);

  typedef enum logic {
    PRI_A   = 1'b0,
    FORCE_B = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] CNT_SAT    = 4'd15;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        grant_a, grant_b;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= PRI_A;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grants depend only on valids, state and reset, never on payload.
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    state_d  = PRI_A;
    starve_d = 4'd0;

    if (rst_n_i) begin
      case (state_q)
        PRI_A: begin
          if (a_valid_i)      grant_a = 1'b1;
          else if (b_valid_i) grant_b = 1'b1;
        end
        FORCE_B: begin
          if (b_valid_i)      grant_b = 1'b1;
          else if (a_valid_i) grant_a = 1'b1;
        end
        default: ;
      endcase
    end

    if (b_valid_i && !grant_b)
      starve_d = (starve_q == CNT_SAT) ? CNT_SAT : starve_q + 4'd1;

    // The edge on which the count reaches the limit arms FORCE_B and clears it.
    if (state_q == PRI_A && starve_d == STARVE_LIM) begin
      state_d  = FORCE_B;
      starve_d = 4'd0;
    end
  end

  assign a_ready_o    = grant_a;
  assign b_ready_o    = grant_b;
  assign starve_cnt_o = starve_q;

  assign xfer     = grant_a | grant_b;
  assign sel_addr = grant_b ? b_addr_i : a_addr_i;
  assign sel_data = grant_b ? b_data_i : a_data_i;

  // Writes to r0 are consumed but never reach the register file.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= 5'd0;
      RDdata_o   <= 32'd0;
    end else if (xfer && sel_addr != 5'd0) begin
      RegWrite_o <= 1'b1;
      RDaddr_o   <= sel_addr;
      RDdata_o   <= sel_data;
    end else begin
      RegWrite_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    assert (!(a_ready_o && b_ready_o))
      else $error("both requesters granted in one cycle");
  end

endmodule
